// File: rtl/mudi_unit_if.sv
// Control/data bundle between the ID-stage decoder/hazard unit and the EX multiply/divide unit.
// The decoder side is the master; the multiply/divide unit is the slave.
interface mudi_unit_if;
    logic [2:0]  MuDiOp;
    logic        MuDiStart;
    logic        MuDiWrite;
    logic        flush;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] MuDiOut;

    // Requests are single-cycle strobes qualified by Busy==0 and flush==0;
    // there is no ready path back, so the hazard unit must hold off mudi/mf/mt ops while Busy is high.
    modport master (
        output MuDiOp, MuDiStart, MuDiWrite, flush, A, B,
        input  Busy, MuDiOut
    );

    modport slave (
        input  MuDiOp, MuDiStart, MuDiWrite, flush, A, B,
        output Busy, MuDiOut
    );
endinterface

// File: rtl/mudi_unit.sv
// Fixed-latency multiply/divide unit owning HI/LO. The result is computed at acceptance into a
// pending pair and committed to HI/LO after the op's busy window has elapsed.
module mudi_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mudi_unit_if.slave  bus,
    output logic [1:0]  state_o
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q, lo_q;
    logic [31:0]        ph_q, pl_q;

    logic               accept;
    logic               do_write;
    logic               is_unsigned;
    logic [63:0]        ext_a, ext_b, product;
    logic               neg_a, neg_b;
    logic [31:0]        mag_a, mag_b, div_b;
    logic [31:0]        q_mag, r_mag;
    logic [31:0]        quo, rem;
    logic [31:0]        res_hi, res_lo;

    // A start always pre-empts a write issued in the same cycle.
    assign accept   = bus.MuDiStart && !busy_q && !bus.flush && !bus.MuDiOp[2];
    assign do_write = bus.MuDiWrite && !bus.MuDiStart && !busy_q && !bus.flush
                      && (bus.MuDiOp == 3'd4 || bus.MuDiOp == 3'd5);

    assign is_unsigned = bus.MuDiOp[0];

    // One 64-bit multiplier serves both forms: only the operand extension differs.
    assign ext_a   = is_unsigned ? {32'b0, bus.A} : {{32{bus.A[31]}}, bus.A};
    assign ext_b   = is_unsigned ? {32'b0, bus.B} : {{32{bus.B[31]}}, bus.B};
    assign product = ext_a * ext_b;

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
    assign neg_a = !is_unsigned && bus.A[31];
    assign neg_b = !is_unsigned && bus.B[31];
    assign mag_a = neg_a ? (32'd0 - bus.A) : bus.A;
    assign mag_b = neg_b ? (32'd0 - bus.B) : bus.B;
    assign div_b = (bus.B == 32'd0) ? 32'd1 : mag_b;
    assign q_mag = mag_a / div_b;
    assign r_mag = mag_a % div_b;

    always_comb begin
        quo = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
        rem = neg_a ? (32'd0 - r_mag) : r_mag;
        if (bus.B == 32'd0) begin
            quo = 32'hFFFF_FFFF;
            rem = bus.A;
        end
    end

    assign res_hi = bus.MuDiOp[1] ? rem : product[63:32];
    assign res_lo = bus.MuDiOp[1] ? quo : product[31:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            ph_q    <= 32'd0;
            pl_q    <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ph_q    <= res_hi;
                        pl_q    <= res_lo;
                        cnt_q   <= bus.MuDiOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end else if (do_write) begin
                        if (bus.MuDiOp[0]) begin
                            lo_q <= bus.A;
                        end else begin
                            hi_q <= bus.A;
                        end
                    end
                end
                BUSY: begin
                    // Requests arriving here are dropped; flush cannot cancel an op in flight.
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= ph_q;
                        lo_q    <= pl_q;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.MuDiOut = 32'd0;
        if (bus.MuDiOp == 3'd6) begin
            bus.MuDiOut = hi_q;
        end else if (bus.MuDiOp == 3'd7) begin
            bus.MuDiOut = lo_q;
        end
    end

    assign bus.Busy = busy_q;
    assign state_o  = state_q;
endmodule
